// File: rtl/cnt_disp_pkg.sv
// cnt_disp_pkg: shared constants for the counter display stage.
//   - Seven-segment glyphs SEG_0..SEG_F, bit order {g,f,e,d,c,b,a}, active-high.
//   - SEG_BLANK (all segments off) and one-hot digit enables DIG_LO / DIG_HI / DIG_OFF.
//   - cnt_sample_t: one snapshot of the counter outputs {QH, QL, C}.
package cnt_disp_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [1:0] DIG_LO  = 2'b01;
   localparam logic [1:0] DIG_HI  = 2'b10;
   localparam logic [1:0] DIG_OFF = 2'b00;

   typedef struct packed {
      logic [3:0] qh;
      logic [3:0] ql;
      logic       c;
   } cnt_sample_t;

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational 4-bit hex to seven-segment decoder.
//   i_hex  - nibble to display
//   o_seg  - segments {g,f,e,d,c,b,a}, active-high; polarity is applied by the parent
module hex7seg
   import cnt_disp_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_hex)
         4'h0: o_seg = SEG_0;
         4'h1: o_seg = SEG_1;
         4'h2: o_seg = SEG_2;
         4'h3: o_seg = SEG_3;
         4'h4: o_seg = SEG_4;
         4'h5: o_seg = SEG_5;
         4'h6: o_seg = SEG_6;
         4'h7: o_seg = SEG_7;
         4'h8: o_seg = SEG_8;
         4'h9: o_seg = SEG_9;
         4'hA: o_seg = SEG_A;
         4'hB: o_seg = SEG_B;
         4'hC: o_seg = SEG_C;
         4'hD: o_seg = SEG_D;
         4'hE: o_seg = SEG_E;
         4'hF: o_seg = SEG_F;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/cnt_disp_scan.sv
// cnt_disp_scan: 2-digit multiplexed seven-segment driver for the counter outputs.
//   Clk  - system clock, rising edge
//   MR   - asynchronous active-low reset
//   QH   - counter high nibble (asynchronous to Clk)
//   QL   - counter low nibble (asynchronous to Clk)
//   C    - counter carry flag (asynchronous to Clk)
//   SEG  - segments {g,f,e,d,c,b,a}, active-low when ACT_LOW=1
//   DIG  - one-hot digit enable, bit0 low digit, bit1 high digit, polarity as SEG
//   CLED - stretched carry indicator, active-high
module cnt_disp_scan
   import cnt_disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned CHOLD    = 100,
   parameter int unsigned BLANK_LZ = 1,
   parameter int unsigned ACT_LOW  = 1
) (
   input  logic       Clk,
   input  logic       MR,
   input  logic [3:0] QH,
   input  logic [3:0] QL,
   input  logic       C,
   output logic [6:0] SEG,
   output logic [1:0] DIG,
   output logic       CLED
);

   localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
   localparam int unsigned HOLD_W = $clog2(CHOLD + 1);

   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(CHOLD);

   // Inactive levels at the pins, used for reset and blanking.
   localparam logic [6:0] SEG_OFF = (ACT_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
   localparam logic [1:0] PIN_DIG_OFF = (ACT_LOW != 0) ? ~DIG_OFF : DIG_OFF;

   cnt_sample_t       r_s1, r_s2, r_s3;
   logic [SCAN_W-1:0] r_scan;
   logic              r_sel;
   logic [3:0]        r_disp_h, r_disp_l;
   logic [HOLD_W-1:0] r_hold;
   logic              r_cled;
   logic [6:0]        r_seg;
   logic [1:0]        r_dig;

   logic              w_stable, w_tick, w_frame, w_c_rise, w_blank;
   logic [3:0]        w_digit;
   logic [6:0]        w_glyph, w_seg_hi;
   logic [1:0]        w_dig_hi;

   // Compare the two settled stages so a mid-change counter value is never captured.
   assign w_stable = (r_s2 == r_s3);
   assign w_tick   = (r_scan == SCAN_LAST);
   // A frame ends when the high digit hands back to the low digit.
   assign w_frame  = w_tick & r_sel;
   assign w_c_rise = r_s2.c & ~r_s3.c;

   always_ff @(posedge Clk or negedge MR) begin
      if (!MR) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
      end else begin
         r_s1 <= '{qh: QH, ql: QL, c: C};
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   always_ff @(posedge Clk or negedge MR) begin
      if (!MR) begin
         r_scan <= '0;
         r_sel  <= 1'b0;
      end else if (w_tick) begin
         r_scan <= '0;
         r_sel  <= ~r_sel;
      end else begin
         r_scan <= r_scan + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge MR) begin
      if (!MR) begin
         r_disp_h <= 4'h0;
         r_disp_l <= 4'h0;
      end else if (w_frame && w_stable) begin
         r_disp_h <= r_s2.qh;
         r_disp_l <= r_s2.ql;
      end
   end

   // A new carry edge reloads the stretch even if a frame decrement is due.
   always_ff @(posedge Clk or negedge MR) begin
      if (!MR) begin
         r_hold <= '0;
         r_cled <= 1'b0;
      end else begin
         if (w_c_rise) begin
            r_hold <= HOLD_INIT;
         end else if (w_frame && (r_hold != '0)) begin
            r_hold <= r_hold - 1'b1;
         end
         r_cled <= (r_hold != '0);
      end
   end

   assign w_digit = r_sel ? r_disp_h : r_disp_l;

   hex7seg u_hex7seg (
      .i_hex (w_digit),
      .o_seg (w_glyph)
   );

   assign w_blank  = (BLANK_LZ != 0) && r_sel && (r_disp_h == 4'h0);
   assign w_seg_hi = w_blank ? SEG_BLANK : w_glyph;
   assign w_dig_hi = r_sel ? DIG_HI : DIG_LO;

   always_ff @(posedge Clk or negedge MR) begin
      if (!MR) begin
         r_seg <= SEG_OFF;
         r_dig <= PIN_DIG_OFF;
      end else if (ACT_LOW != 0) begin
         r_seg <= ~w_seg_hi;
         r_dig <= ~w_dig_hi;
      end else begin
         r_seg <= w_seg_hi;
         r_dig <= w_dig_hi;
      end
   end

   assign SEG  = r_seg;
   assign DIG  = r_dig;
   assign CLED = r_cled;

endmodule

// File: tb/tb_cnt_disp_scan.sv
// tb_cnt_disp_scan: directed, scoreboard-driven bench for cnt_disp_scan.
// Two instances share stimulus: u_dut_a is active-high, u_dut_b is active-low.
// Expectations are queued with the clock edge (counted from reset release)
// at which they must hold, and are checked at the following falling edge.
module tb_cnt_disp_scan;

   localparam int SIG_SEG_A  = 0;
   localparam int SIG_DIG_A  = 1;
   localparam int SIG_CLED_A = 2;
   localparam int SIG_SEG_B  = 3;
   localparam int SIG_DIG_B  = 4;
   localparam int SIG_CLED_B = 5;

   typedef struct {
      int         at;
      string      tag;
      int         sig;
      logic [6:0] val;
   } exp_t;

   logic       clk = 1'b0;
   logic       mr  = 1'b0;
   logic [3:0] qh  = 4'h0;
   logic [3:0] ql  = 4'h0;
   logic       c   = 1'b0;
   logic [6:0] seg_a, seg_b;
   logic [1:0] dig_a, dig_b;
   logic       cled_a, cled_b;

   int   n_asserts = 0;
   int   n_fails   = 0;
   int   edge_n    = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   cnt_disp_scan #(
      .SCAN_DIV (4),
      .CHOLD    (3),
      .BLANK_LZ (1),
      .ACT_LOW  (0)
   ) u_dut_a (
      .Clk  (clk),
      .MR   (mr),
      .QH   (qh),
      .QL   (ql),
      .C    (c),
      .SEG  (seg_a),
      .DIG  (dig_a),
      .CLED (cled_a)
   );

   cnt_disp_scan #(
      .SCAN_DIV (4),
      .CHOLD    (3),
      .BLANK_LZ (1),
      .ACT_LOW  (1)
   ) u_dut_b (
      .Clk  (clk),
      .MR   (mr),
      .QH   (qh),
      .QL   (ql),
      .C    (c),
      .SEG  (seg_b),
      .DIG  (dig_b),
      .CLED (cled_b)
   );

   function automatic logic [6:0] observe(int sig);
      case (sig)
         SIG_SEG_A:  return seg_a;
         SIG_DIG_A:  return {5'b0, dig_a};
         SIG_CLED_A: return {6'b0, cled_a};
         SIG_SEG_B:  return seg_b;
         SIG_DIG_B:  return {5'b0, dig_b};
         default:    return {6'b0, cled_b};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
      n_asserts++;
      assert (obs === exp_v) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic expect_at(input int at, input string tag, input int sig,
                            input logic [6:0] val);
      exp_t e;
      e.at  = at;
      e.tag = tag;
      e.sig = sig;
      e.val = val;
      sb.push_back(e);
   endtask

   // Advance falling edge by falling edge, draining expectations due at each edge.
   task automatic run_to(input int k);
      exp_t e;
      while (edge_n < k) begin
         @(negedge clk);
         edge_n++;
         while (sb.size() > 0 && sb[0].at == edge_n) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sig), e.val);
         end
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      chk({pfx, "_seg_a"},  seg_a, 7'h00);
      chk({pfx, "_dig_a"},  {5'b0, dig_a}, 7'h00);
      chk({pfx, "_cled_a"}, {6'b0, cled_a}, 7'h00);
      chk({pfx, "_seg_b"},  seg_b, 7'h7F);
      chk({pfx, "_dig_b"},  {5'b0, dig_b}, 7'h03);
      chk({pfx, "_cled_b"}, {6'b0, cled_b}, 7'h00);
   endtask

   initial begin
      // Reset held from time zero.
      #12;
      check_reset_outputs("rst");
      @(negedge clk);
      mr     = 1'b1;
      edge_n = 0;

      // Inputs at zero: low digit '0', then blanked high digit; 4 cycles per phase.
      expect_at(1, "t1_lo_seg",   SIG_SEG_A,  7'h3F);
      expect_at(1, "t1_lo_dig",   SIG_DIG_A,  7'h01);
      expect_at(1, "t1_cled",     SIG_CLED_A, 7'h00);
      expect_at(1, "t1_lo_seg_b", SIG_SEG_B,  7'h40);
      expect_at(1, "t1_lo_dig_b", SIG_DIG_B,  7'h02);
      expect_at(4, "t1_lo_end",   SIG_DIG_A,  7'h01);
      expect_at(5, "t1_hi_blank", SIG_SEG_A,  7'h00);
      expect_at(5, "t1_hi_dig",   SIG_DIG_A,  7'h02);
      expect_at(5, "t1_hi_blk_b", SIG_SEG_B,  7'h7F);
      expect_at(8, "t1_hi_end",   SIG_DIG_A,  7'h02);
      expect_at(9, "t1_lo2_dig",  SIG_DIG_A,  7'h01);
      expect_at(9, "t1_lo2_seg",  SIG_SEG_A,  7'h3F);
      run_to(9);

      // Steady 4/7 is captured at the frame ending at edge 16.
      qh = 4'h4;
      ql = 4'h7;
      expect_at(16, "t2_pre_cap", SIG_SEG_A, 7'h00);
      expect_at(17, "t2_lo_seg",  SIG_SEG_A, 7'h07);
      expect_at(17, "t2_lo_dig",  SIG_DIG_A, 7'h01);
      expect_at(20, "t2_lo_end",  SIG_SEG_A, 7'h07);
      expect_at(21, "t2_hi_seg",  SIG_SEG_A, 7'h66);
      expect_at(21, "t2_hi_dig",  SIG_DIG_A, 7'h02);
      expect_at(24, "t2_hi_end",  SIG_SEG_A, 7'h66);
      expect_at(25, "t2_lo2_seg", SIG_SEG_A, 7'h07);
      expect_at(25, "t2_lo2_dig", SIG_DIG_A, 7'h01);

      // QL toggles every cycle around the frame at edge 32: no capture there.
      expect_at(33, "t3_unstable", SIG_SEG_A, 7'h07);
      for (int k = 25; k <= 32; k++) begin
         run_to(k);
         ql = (k % 2 == 1) ? 4'h1 : 4'h2;
      end
      run_to(33);
      ql = 4'h9;
      expect_at(36, "t3_hold",    SIG_SEG_A, 7'h07);
      expect_at(41, "t3_capture", SIG_SEG_A, 7'h6F);
      run_to(41);

      // Carry pulse: CLED rises 4 edges after sampling, lasts 3 frames;
      // a second pulse while lit reloads the stretch.
      c = 1'b1;
      expect_at(44, "t4_cled_pre",  SIG_CLED_A, 7'h00);
      expect_at(45, "t4_cled_rise", SIG_CLED_A, 7'h01);
      expect_at(45, "t4_cled_b",    SIG_CLED_B, 7'h01);
      expect_at(56, "t4_cled_mid",  SIG_CLED_A, 7'h01);
      run_to(42);
      c = 1'b0;
      run_to(57);
      c = 1'b1;
      expect_at(65, "t4_reloaded",  SIG_CLED_A, 7'h01);
      expect_at(80, "t4_cled_last", SIG_CLED_A, 7'h01);
      expect_at(81, "t4_cled_fall", SIG_CLED_A, 7'h00);
      expect_at(81, "t4_fall_b",    SIG_CLED_B, 7'h00);
      run_to(58);
      c = 1'b0;
      run_to(81);

      // E/F on both polarities.
      qh = 4'hE;
      ql = 4'hF;
      expect_at(89, "t5_lo_seg_a", SIG_SEG_A, 7'h71);
      expect_at(89, "t5_lo_dig_a", SIG_DIG_A, 7'h01);
      expect_at(89, "t5_lo_seg_b", SIG_SEG_B, 7'h0E);
      expect_at(89, "t5_lo_dig_b", SIG_DIG_B, 7'h02);
      expect_at(93, "t5_hi_seg_a", SIG_SEG_A, 7'h79);
      expect_at(93, "t5_hi_dig_a", SIG_DIG_A, 7'h02);
      expect_at(93, "t5_hi_seg_b", SIG_SEG_B, 7'h06);
      expect_at(93, "t5_hi_dig_b", SIG_DIG_B, 7'h01);
      run_to(93);

      // Carry edge lands on the frame cycle before edge 96: reload must win.
      c = 1'b1;
      expect_at(99, "t6_cled_on_a", SIG_CLED_A, 7'h01);
      expect_at(99, "t6_cled_on_b", SIG_CLED_B, 7'h01);
      run_to(94);
      c = 1'b0;
      run_to(99);

      // Asynchronous reset mid-scan.
      #1;
      mr = 1'b0;
      #1;
      check_reset_outputs("t6_async");
      @(negedge clk);
      mr     = 1'b1;
      edge_n = 0;
      expect_at(1, "t6_restart_seg", SIG_SEG_A,  7'h3F);
      expect_at(1, "t6_restart_dig", SIG_DIG_A,  7'h01);
      expect_at(1, "t6_restart_cl",  SIG_CLED_A, 7'h00);
      expect_at(1, "t6_restart_sgb", SIG_SEG_B,  7'h40);
      expect_at(1, "t6_restart_dgb", SIG_DIG_B,  7'h02);
      expect_at(5, "t6_hi_blank",    SIG_SEG_A,  7'h00);
      run_to(5);

      chk("sb_drained", 7'(sb.size()), 7'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
